// File: rtl/temp_bcd_formatter.sv
// temp_bcd_formatter
// Watches the signed temperature byte from the I2C master, captures it on
// change (and once after reset), and converts |temp| to three BCD digits
// plus a sign flag with an iterative shift-add-3 (double-dabble) engine.
//
// Optional feature macro: TEMP_AVG_EN
//   When defined, a 4-sample moving window is averaged (floor) before
//   conversion, adding one LOAD edge between capture and engine load.
//
// Output semantics (consumer side, no back-pressure):
//   - digit_* and negative are registered together and hold between
//     conversions, so they may be read at any time.
//   - update pulses for exactly one cycle after new digits are written.
//   - valid rises with the first completed conversion and stays high
//     until reset.
//   - busy is high from the cycle after capture through the cycle that
//     ends with the final shift edge.
module temp_bcd_formatter (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] temp_data,
  output logic [3:0] digit_hundreds,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       negative,
  output logic       valid,
  output logic       busy,
  output logic       update
);

  // LOAD is only entered when the averaging window is built in.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [7:0]  last_data;
  logic        prime;
  logic [19:0] shift_q;
  logic [19:0] shift_next;
  logic [2:0]  count_q;
  logic        negative_n;

  logic        changed;
  logic        capture;
  logic        load_engine;
  logic        shift_en;
  logic        finish;

  logic [7:0]  src;
  logic [7:0]  magnitude;

  // One double-dabble step: add 3 to every BCD nibble that is 5 or more,
  // then shift the whole register left by one.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  assign changed    = prime || (temp_data != last_data);
  assign shift_next = dabble_step(shift_q);
  // -128 negates to 8'h80, which read unsigned is the required 128.
  assign magnitude  = src[7] ? (8'd0 - src) : src;

`ifdef TEMP_AVG_EN
  logic [7:0] win_q [4];
  logic [9:0] win_sum;

  // Signed 10-bit sum of the window; bits [9:2] are the floor of sum/4.
  always_comb begin
    win_sum = {{2{win_q[0][7]}}, win_q[0]}
            + {{2{win_q[1][7]}}, win_q[1]}
            + {{2{win_q[2][7]}}, win_q[2]}
            + {{2{win_q[3][7]}}, win_q[3]};
  end

  assign src = win_sum[9:2];

  // Window shift on capture; the first capture after reset fills all slots.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) win_q[i] <= 8'd0;
    end else if (capture) begin
      if (prime) begin
        for (int i = 0; i < 4; i++) win_q[i] <= temp_data;
      end else begin
        win_q[0] <= temp_data;
        win_q[1] <= win_q[0];
        win_q[2] <= win_q[1];
        win_q[3] <= win_q[2];
      end
    end
  end
`else
  assign src = temp_data;
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-edge control strobes.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    load_engine = 1'b0;
    shift_en    = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        if (changed) begin
          capture = 1'b1;
`ifdef TEMP_AVG_EN
          state_d = LOAD;
`else
          load_engine = 1'b1;
          state_d     = CONVERT;
`endif
        end
      end
      LOAD: begin
        load_engine = 1'b1;
        state_d     = CONVERT;
      end
      CONVERT: begin
        shift_en = 1'b1;
        if (count_q == 3'd7) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture bookkeeping: last seen sample and the post-reset prime flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_data <= 8'd0;
      prime     <= 1'b1;
    end else if (capture) begin
      last_data <= temp_data;
      prime     <= 1'b0;
    end
  end

  // Conversion engine: load magnitude and sign, then eight dabble shifts.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q    <= 20'd0;
      count_q    <= 3'd0;
      negative_n <= 1'b0;
    end else if (load_engine) begin
      shift_q    <= {12'd0, magnitude};
      count_q    <= 3'd0;
      negative_n <= src[7];
    end else if (shift_en) begin
      shift_q    <= shift_next;
      count_q    <= count_q + 3'd1;
    end
  end

  // Output registers: digits and sign update together on the final shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      digit_hundreds <= 4'd0;
      digit_tens     <= 4'd0;
      digit_ones     <= 4'd0;
      negative       <= 1'b0;
      valid          <= 1'b0;
      busy           <= 1'b0;
      update         <= 1'b0;
    end else begin
      update <= 1'b0;
      if (capture) busy <= 1'b1;
      if (finish) begin
        digit_hundreds <= shift_next[19:16];
        digit_tens     <= shift_next[15:12];
        digit_ones     <= shift_next[11:8];
        // A zero magnitude never reports a sign.
        negative       <= negative_n && (shift_next[19:8] != 12'd0);
        valid          <= 1'b1;
        update         <= 1'b1;
        busy           <= 1'b0;
      end
    end
  end

endmodule
